// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data memory (data_mem_ws).
// Optional misalignment checking is enabled with the DMEM_MISALIGN_CHECK_EN macro.
package dmem_pkg;

  // RISC-V funct3 access sizes; 011, 110 and 111 are treated as word accesses.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LATENCY_MIN = 0;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/data_mem_ws_if.sv
// MEM-stage request/response bundle for data_mem_ws.
interface data_mem_ws_if #(
  parameter int ADDR_W = 32
);
  // Handshake: the master raises memRead or memWrite (memWrite wins if both are
  // high) together with funct3/address/writeData and holds all of them stable
  // until it sees memReady; memReady is a one-cycle pulse, readData/misaligned
  // are valid with it, and the master drops or changes its request at the edge
  // that ends the memReady cycle. The pipeline stalls on (memRead|memWrite) & ~memReady.
  logic              memRead;
  logic              memWrite;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writeData;
  logic [31:0]       readData;
  logic              memReady;
  logic              misaligned;

  modport master (
    output memRead, memWrite, funct3, address, writeData,
    input  readData, memReady, misaligned
  );

  modport slave (
    input  memRead, memWrite, funct3, address, writeData,
    output readData, memReady, misaligned
  );

endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering for stores, extraction/extension for loads and the
// misalignment detect (active only when DMEM_MISALIGN_CHECK_EN is defined).
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    byte_en    = 4'hF;
    wdata_lane = wdata;
    rdata      = rword;
    sel_byte   = rword[{offset, 3'b000} +: 8];
    sel_half   = offset[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      LB, LBU: begin
        byte_en    = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata      = {{24{sel_byte[7] & (funct3 == LB)}}, sel_byte};
      end
      // Halfword lane comes from offset[1] only, so address[0] is ignored here.
      LH, LHU: begin
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata      = {{16{sel_half[15] & (funct3 == LH)}}, sel_half};
      end
      default: begin
        byte_en    = 4'hF;
        wdata_lane = wdata;
        rdata      = rword;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if ((funct3 == LH) || (funct3 == LHU))
      misaligned = offset[0];
    else if (funct3[1])
      misaligned = (offset != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/data_mem_ws.sv
// Handshaked MEM-stage data memory with LATENCY wait states and sub-word access.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned accesses.
module data_mem_ws
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_ws_if.slave  bus,
  output state_e        dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LAT_CLAMPED = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                               (LATENCY < LATENCY_MIN) ? LATENCY_MIN : LATENCY;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_CLAMPED);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_write_q;
  logic [2:0]         f3_q;
  logic [IDX_W+1:0]   addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        read_data_q;
  logic               mis_q;

  logic               accept;
  logic               perform;
  logic [31:0]        rword;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_lane;
  logic [31:0]        lane_rdata;
  logic               lane_mis;
  logic               unused_addr_hi;

  logic [31:0] mem [DEPTH_WORDS];

  // Bits above the word index are ignored, so addresses wrap around the array.
  assign unused_addr_hi = ^bus.address[ADDR_W-1:IDX_W+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    perform = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.memRead || bus.memWrite) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          perform = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      op_write_q  <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q      <= CNT_INIT;
        op_write_q <= bus.memWrite;
        f3_q       <= bus.funct3;
        addr_q     <= bus.address[IDX_W+1:0];
        wdata_q    <= bus.writeData;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (perform) begin
        mis_q <= lane_mis;
        if (!op_write_q && !lane_mis)
          read_data_q <= lane_rdata;
      end
    end
  end

  // perform depends on the async-reset state, so a reset before this edge drops the write.
  always_ff @(posedge clk) begin
    if (perform && op_write_q && !lane_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[addr_q[IDX_W+1:2]][i*8 +: 8] <= wdata_lane[i*8 +: 8];
      end
    end
  end

  assign rword = mem[addr_q[IDX_W+1:2]];

  dmem_lane u_lane (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata      (lane_rdata),
    .misaligned (lane_mis)
  );

  assign bus.readData   = read_data_q;
  assign bus.memReady   = (state_q == RESP);
  assign bus.misaligned = mis_q & (state_q == RESP);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboarded random/directed bench for data_mem_ws; honours DMEM_MISALIGN_CHECK_EN.
module tb_data_mem_ws;
  import dmem_pkg::*;

  localparam int LAT   = 1;
  localparam int DEPTH = 256;
  localparam int BYTES = 4 * DEPTH;
  localparam int W     = 65;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  state_e       dbg_state;
  logic [31:0]  cyc;
  int           n_checks;
  int           n_fail;

  logic [7:0]   mem_b [BYTES];
  logic [31:0]  rd_model;
  logic [W-1:0] exp_q[$];

  data_mem_ws_if #(.ADDR_W(32)) bus ();

  data_mem_ws #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (32),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  task automatic model_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd);
    int a, nb, base;
    bit mis;
    logic [31:0] val;
    a    = int'(addr % BYTES);
    nb   = f3[1] ? 4 : (f3[0] ? 2 : 1);
    base = a - (a % nb);
    mis  = CHECK && ((a % nb) != 0);
    if (wr) begin
      if (!mis)
        for (int i = 0; i < nb; i++) mem_b[base + i] = wd[8*i +: 8];
    end else if (rd && !mis) begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val = val | (32'(mem_b[base + i]) << (8*i));
      if (nb < 4 && !f3[2] && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      rd_model = val;
    end
    exp_q.push_back({rd_model, mis, cyc + 32'(LAT + 2)});
  endtask

  // ---------------- driver ----------------
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int k;
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.funct3    = f3;
    bus.address   = addr;
    bus.writeData = wd;
    model_access(rd, wr, f3, addr, wd);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (bus.memReady) break;
      k++;
    end
    if (k >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no memReady for addr=%h f3=%b", addr, f3);
    end
    @(posedge clk);
    #1;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] exp_e;
  always @(negedge clk) begin
    if (rst_n && bus.memReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: memReady at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_e = exp_q.pop_front();
        n_checks += 3;
        if (bus.readData !== exp_e[64:33]) begin
          n_fail++;
          $display("FAIL readData: got %h expected %h (cycle %0d)", bus.readData, exp_e[64:33], cyc);
        end
        if (bus.misaligned !== exp_e[32]) begin
          n_fail++;
          $display("FAIL misaligned: got %b expected %b (cycle %0d)", bus.misaligned, exp_e[32], cyc);
        end
        if (cyc !== exp_e[31:0]) begin
          n_fail++;
          $display("FAIL latency: memReady at cycle %0d expected %0d", cyc, exp_e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int op, wait_k;
    logic [31:0] ra;
    cyc           = 0;
    n_checks      = 0;
    n_fail        = 0;
    rd_model      = 32'h0;
    rst_n         = 1'b0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.funct3    = 3'b000;
    bus.address   = 32'h0;
    bus.writeData = 32'h0;
    #12;
    check_val("reset_readData",   bus.readData,          32'h0);
    check_val("reset_memReady",   32'(bus.memReady),     32'h0);
    check_val("reset_misaligned", 32'(bus.misaligned),   32'h0);
    check_val("reset_state",      32'(dbg_state),        32'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Prefill the first 16 words so every later load is defined.
    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom);

    access(1'b0, 1'b1, 3'b010, 32'd32, 32'h1234_5678);
    access(1'b1, 1'b0, 3'b010, 32'd32, 32'h0);
    access(1'b0, 1'b1, 3'b000, 32'd33, 32'hFFFF_FFAB);
    access(1'b1, 1'b0, 3'b010, 32'd32, 32'h0);
    access(1'b1, 1'b0, 3'b000, 32'd33, 32'h0);
    access(1'b1, 1'b0, 3'b100, 32'd33, 32'h0);
    access(1'b1, 1'b0, 3'b101, 32'd34, 32'h0);
    access(1'b0, 1'b1, 3'b010, 32'd1060, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 3'b010, 32'd36, 32'h0);
    access(1'b1, 1'b1, 3'b010, 32'd40, 32'h5555_AAAA);
    access(1'b1, 1'b0, 3'b010, 32'd40, 32'h0);
    access(1'b0, 1'b1, 3'b010, 32'd34, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 3'b010, 32'd32, 32'h0);
    access(1'b0, 1'b1, 3'b001, 32'd45, 32'h0000_9A7C);
    access(1'b1, 1'b0, 3'b001, 32'd44, 32'h0);
    access(1'b1, 1'b0, 3'b110, 32'd44, 32'h0);

    // Randomised mix of sizes, lanes, wrapped addresses and read/write/both.
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 3);
      ra = 32'($urandom_range(0, 63)) + 32'(BYTES) * 32'($urandom_range(0, 3));
      access(op <= 1 || op == 3, op >= 2, 3'($urandom_range(0, 7)), ra, $urandom);
    end

    // Reset while the store sits in BUSY: the store must vanish.
    bus.memWrite  = 1'b1;
    bus.funct3    = 3'b010;
    bus.address   = 32'd32;
    bus.writeData = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    #2 rst_n = 1'b0;
    bus.memWrite = 1'b0;
    #1;
    check_val("abort_readData",   bus.readData,        32'h0);
    check_val("abort_memReady",   32'(bus.memReady),   32'h0);
    check_val("abort_misaligned", 32'(bus.misaligned), 32'h0);
    check_val("abort_state",      32'(dbg_state),      32'(IDLE));
    rd_model = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 3'b010, 32'd32, 32'h0);
    access(1'b1, 1'b0, 3'b100, 32'd35, 32'h0);

    wait_k = 0;
    while (exp_q.size() != 0 && wait_k < 50) begin
      @(posedge clk);
      wait_k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses still outstanding", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
